// File: rtl/threshold_pkg.sv
// Shared encodings and defaults for the threshold pipeline and its per-mask compare slice.
package threshold_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_NUM_MASKS = 3;
  localparam int unsigned DEF_CNT_W     = 20;

  typedef enum logic [2:0] {
    SEL_G      = 3'd0,
    SEL_R      = 3'd1,
    SEL_B      = 3'd2,
    SEL_ZERO_A = 3'd3,
    SEL_Y      = 3'd4,
    SEL_CR     = 3'd5,
    SEL_CB     = 3'd6,
    SEL_ZERO_B = 3'd7
  } chan_sel_e;

  typedef enum logic [1:0] {
    FLD_LOWER  = 2'd0,
    FLD_UPPER  = 2'd1,
    FLD_SOURCE = 2'd2,
    FLD_RSVD   = 2'd3
  } cfg_field_e;

  // A zero source can never sit strictly between bounds, so this disables a mask.
  localparam chan_sel_e SRC_RESET = SEL_ZERO_A;

endpackage

// File: rtl/threshold_cmp.sv
// One mask: strict window compare registered as stage 2, plus the saturating per-frame counter.
module threshold_cmp
  import threshold_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] lower_in,
  input  logic [WIDTH-1:0] upper_in,
  input  logic [WIDTH-1:0] source_in,
  input  logic             pix_valid_in,
  input  logic             pix_fs_in,
  output logic             mask_out,
  output logic [CNT_W-1:0] count_out
);

  logic [CNT_W-1:0] acc;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mask_out  <= 1'b0;
      acc       <= '0;
      count_out <= '0;
    end else begin
      mask_out <= valid_in && (lower_in < source_in) && (source_in < upper_in);
      if (pix_valid_in) begin
        // Frame-start pixel closes the old frame and seeds the new one with its own bit.
        if (pix_fs_in) begin
          count_out <= acc;
          acc       <= CNT_W'(mask_out);
        end else if (mask_out && (acc != '1)) begin
          acc <= acc + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/threshold_pipe.sv
// Two-stage colour threshold pipeline with frame-aligned shadow configuration and per-mask counts.
module threshold_pipe
  import threshold_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned NUM_MASKS = DEF_NUM_MASKS,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          valid_in,
  input  logic                          frame_start_in,
  input  logic [WIDTH-1:0]              r_in,
  input  logic [WIDTH-1:0]              g_in,
  input  logic [WIDTH-1:0]              b_in,
  input  logic [WIDTH-1:0]              y_in,
  input  logic [WIDTH-1:0]              cr_in,
  input  logic [WIDTH-1:0]              cb_in,
  input  logic [2:0]                    sel_in,
  input  logic                          cfg_we_in,
  input  logic [$clog2(NUM_MASKS)+1:0]  cfg_addr_in,
  input  logic [WIDTH-1:0]              cfg_data_in,
  output logic                          valid_out,
  output logic [WIDTH-1:0]              channel_out,
  output logic [NUM_MASKS-1:0]          mask_out,
  output logic                          mask_and_out,
  output logic [NUM_MASKS*CNT_W-1:0]    count_out,
  output logic                          count_valid_out
);

  localparam int unsigned AW = $clog2(NUM_MASKS) + 2;

  function automatic logic [WIDTH-1:0] chan_mux(
    input logic [2:0]       sel,
    input logic [WIDTH-1:0] r, g, b, y, cr, cb
  );
    case (chan_sel_e'(sel))
      SEL_G:   return g;
      SEL_R:   return r;
      SEL_B:   return b;
      SEL_Y:   return y;
      SEL_CR:  return cr;
      SEL_CB:  return cb;
      default: return '0;
    endcase
  endfunction

  logic [WIDTH-1:0] sh_lo  [NUM_MASKS];
  logic [WIDTH-1:0] sh_hi  [NUM_MASKS];
  logic [2:0]       sh_src [NUM_MASKS];
  logic [WIDTH-1:0] act_lo [NUM_MASKS];
  logic [WIDTH-1:0] act_hi [NUM_MASKS];
  logic [2:0]       act_src[NUM_MASKS];
  logic [WIDTH-1:0] s1_src [NUM_MASKS];

  logic             s1_valid, s1_fs, s2_fs;
  logic [WIDTH-1:0] s1_chan;
  logic [AW-1:0]    cfg_idx;
  cfg_field_e       cfg_fld;
  logic             load_act;

  assign cfg_idx      = cfg_addr_in >> 2;
  assign cfg_fld      = cfg_field_e'(cfg_addr_in[1:0]);
  assign load_act     = valid_in && frame_start_in;
  assign mask_and_out = &mask_out;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned k = 0; k < NUM_MASKS; k++) begin
        sh_lo[k]  <= '0;
        sh_hi[k]  <= '0;
        sh_src[k] <= SRC_RESET;
      end
    end else if (cfg_we_in) begin
      for (int unsigned k = 0; k < NUM_MASKS; k++) begin
        if (32'(cfg_idx) == k) begin
          case (cfg_fld)
            FLD_LOWER:  sh_lo[k]  <= cfg_data_in;
            FLD_UPPER:  sh_hi[k]  <= cfg_data_in;
            FLD_SOURCE: sh_src[k] <= cfg_data_in[2:0];
            default:    ;
          endcase
        end
      end
    end
  end

  // Active set loads as the frame-start pixel enters stage 1, so it is already in place while
  // that pixel is compared; a write in the same cycle only reaches shadow and waits a frame.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned k = 0; k < NUM_MASKS; k++) begin
        act_lo[k]  <= '0;
        act_hi[k]  <= '0;
        act_src[k] <= SRC_RESET;
      end
    end else if (load_act) begin
      for (int unsigned k = 0; k < NUM_MASKS; k++) begin
        act_lo[k]  <= sh_lo[k];
        act_hi[k]  <= sh_hi[k];
        act_src[k] <= sh_src[k];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0;
      s1_fs    <= 1'b0;
      s1_chan  <= '0;
      for (int unsigned k = 0; k < NUM_MASKS; k++) s1_src[k] <= '0;
    end else begin
      s1_valid <= valid_in;
      s1_fs    <= load_act;
      s1_chan  <= chan_mux(sel_in, r_in, g_in, b_in, y_in, cr_in, cb_in);
      for (int unsigned k = 0; k < NUM_MASKS; k++) begin
        s1_src[k] <= chan_mux(load_act ? sh_src[k] : act_src[k],
                              r_in, g_in, b_in, y_in, cr_in, cb_in);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_out       <= 1'b0;
      s2_fs           <= 1'b0;
      channel_out     <= '0;
      count_valid_out <= 1'b0;
    end else begin
      valid_out       <= s1_valid;
      s2_fs           <= s1_valid && s1_fs;
      channel_out     <= s1_valid ? s1_chan : '0;
      count_valid_out <= valid_out && s2_fs;
    end
  end

  for (genvar k = 0; k < NUM_MASKS; k++) begin : g_mask
    threshold_cmp #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
    ) u_cmp (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .valid_in    (s1_valid),
      .lower_in    (act_lo[k]),
      .upper_in    (act_hi[k]),
      .source_in   (s1_src[k]),
      .pix_valid_in(valid_out),
      .pix_fs_in   (s2_fs),
      .mask_out    (mask_out[k]),
      .count_out   (count_out[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: doc/threshold_pipe.md
THRESHOLD_PIPE -- requirements
Module: threshold_pipe

Interface
REQ-001 Parameter WIDTH, default 8, bit width of every colour channel and bound.
REQ-002 Parameter NUM_MASKS, default 3, number of independent threshold masks.
REQ-003 Parameter CNT_W, default 20, width of each per-frame mask pixel counter.
REQ-004 clk_in  input  1  pixel clock; the block's only clock.
REQ-005 rst_in  input  1  synchronous, active-high reset.
REQ-006 valid_in  input  1  pixel qualifier.
REQ-007 frame_start_in  input  1  marks the current valid pixel as first of a frame; ignored when valid_in is low.
REQ-008 r_in, g_in, b_in, y_in, cr_in, cb_in  input  WIDTH each  pixel channels.
REQ-009 sel_in  input  3  display channel select: 0 g, 1 r, 2 b, 4 y, 5 cr, 6 cb, 3/7 zero.
REQ-010 cfg_we_in  input  1  config write strobe.
REQ-011 cfg_addr_in  input  $clog2(NUM_MASKS)+2  {mask index, field}; field 0 lower, 1 upper, 2 source select (sel_in encoding), 3 reserved.
REQ-012 cfg_data_in  input  WIDTH  config write data; source field uses bits [2:0].
REQ-013 valid_out  output  1  valid_in delayed two cycles.
REQ-014 channel_out  output  WIDTH  selected display channel, aligned with valid_out.
REQ-015 mask_out  output  NUM_MASKS  per-mask result, aligned with valid_out.
REQ-016 mask_and_out  output  1  AND of all mask_out bits.
REQ-017 count_out  output  NUM_MASKS*CNT_W  per-mask count of set pixels in the previous frame; mask k in bits [k*CNT_W +: CNT_W].
REQ-018 count_valid_out  output  1  one-cycle pulse when count_out updates.

Function
REQ-019 Pipeline: stage 1 registers display channel and NUM_MASKS source channels; stage 2 registers compares; latency exactly 2 cycles, throughput one pixel per cycle, no stalls.
REQ-020 Mask k is set iff lower_k < source_k < upper_k, unsigned, strict; lower_k >= upper_k yields 0.
REQ-021 Source select 3 or 7 yields a zero source, so the mask is set iff lower_k < 0 < upper_k, which never holds.
REQ-022 Config writes land in shadow registers on the write cycle; writes to field 3 or mask index >= NUM_MASKS are ignored.
REQ-023 Active registers load from shadow in the cycle a frame_start-flagged pixel sits in stage 1; that pixel and all later pixels use the new values.
REQ-024 A config write in the same cycle as the shadow-to-active copy: the copy takes the old shadow value; the new value waits for the next frame.
REQ-025 Per-mask accumulators increment on each valid stage-2 pixel with mask set; they saturate at 2^CNT_W-1.
REQ-026 When the frame_start pixel is in stage 2: count_out latches the accumulators, count_valid_out pulses high, and each accumulator restarts at that pixel's mask bit (0 or 1).
REQ-027 A frame_start pixel before any earlier frame start latches whatever has accumulated since reset.
REQ-028 When valid_out is low, mask_out, mask_and_out and channel_out are zero.
REQ-029 sel_in is sampled per pixel at stage 1 and needs no frame alignment.

Reset
REQ-030 Reset clears all pipeline registers, valid_out, mask_out, mask_and_out, channel_out, count_out, count_valid_out and the accumulators.
REQ-031 Reset sets shadow and active lower to 0, upper to 0 and source to 3, so all masks are disabled.
REQ-032 Reset mid-frame discards in-flight pixels; the next frame_start pixel produces count_valid_out with counts accumulated since reset.

Structure
REQ-033 A shared package threshold_pkg holds the channel-select encoding constants, the config field constants and the default parameter values.
REQ-034 One sub-module, threshold_cmp, holds a single mask's compare and saturating accumulator; it is instantiated NUM_MASKS times via generate.

Verification
REQ-035 WIDTH=8: mask0 lower 10, upper 20, source 5 (cr); cr_in 10, 11, 19, 20 -> mask_out[0] 0, 1, 1, 0, each two cycles after its pixel.
REQ-036 Shadow timing: write upper 50 mid-frame -> no effect until the next frame_start pixel; a write coincident with the copy is deferred one frame.
REQ-037 Counting: 100-pixel frame with 37 pixels in range, then frame_start -> count_valid_out pulse, count_out[0] = 37, accumulator restarts.
REQ-038 Saturation: CNT_W=4, 20 in-range pixels -> count 15.
REQ-039 valid_in gaps and sel_in sweep 0..7 -> channel_out follows the select encoding with latency 2; bubbles give zero outputs and no count change.
REQ-040 Reset asserted mid-frame -> all outputs 0 next cycle; masks disabled until reconfigured.
